// File: rtl/sata_speed_negotiator_if.sv
// Control/status bundle between the link-layer controller, the speed
// negotiator and the OOB link-init block.
interface sata_speed_negotiator_if;
  logic       enable;
  logic       phy_ready;
  logic       oob_linkup;
  logic       retrain;
  logic [1:0] gen;
  logic       oob_reset;
  logic       link_up;
  logic       busy;
  logic       fail;
  logic [1:0] attempt;
  logic [2:0] state_dbg;

  // Controller / environment side: drives requests and PHY status
  modport master (
    output enable, phy_ready, oob_linkup, retrain,
    input  gen, oob_reset, link_up, busy, fail, attempt, state_dbg
  );

  // Negotiator side
  modport slave (
    input  enable, phy_ready, oob_linkup, retrain,
    output gen, oob_reset, link_up, busy, fail, attempt, state_dbg
  );
endinterface

// File: rtl/sata_speed_negotiator.sv
// SATA speed negotiator: walks the OOB link-init block down from MAX_GEN,
// retrying each generation, until a stable linkup is seen or every
// generation has been exhausted.
module sata_speed_negotiator #(
  parameter int unsigned MAX_GEN         = 2,
  parameter logic [23:0] TIMEOUT_CYCLES  = 24'd1000000,
  parameter int unsigned RETRIES_PER_GEN = 2,
  parameter int unsigned RESET_HOLD      = 16,
  parameter int unsigned STABLE_CYCLES   = 1024
) (
  input logic                    clk,
  input logic                    reset,
  sata_speed_negotiator_if.slave nif
);

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RESET_OOB    = 3'd1,
    ST_WAIT_LINK    = 3'd2,
    ST_CHECK_STABLE = 3'd3,
    ST_LINKED       = 3'd4,
    ST_FAILED       = 3'd5
  } state_e;

  localparam logic [1:0]  GEN_TOP      = 2'(MAX_GEN);
  localparam logic [1:0]  RETRY_LAST   = 2'(RETRIES_PER_GEN - 1);
  localparam logic [23:0] HOLD_LAST    = 24'(RESET_HOLD - 1);
  localparam logic [23:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 24'd1;
  localparam logic [23:0] STABLE_LAST  = 24'(STABLE_CYCLES - 1);

  state_e      state_r;
  state_e      state_nxt_s;
  logic [23:0] timer_r;
  logic [23:0] timer_nxt_s;
  logic [1:0]  gen_r;
  logic [1:0]  gen_nxt_s;
  logic [1:0]  attempt_r;
  logic [1:0]  attempt_nxt_s;

  state_e      fb_state_s;
  logic [1:0]  fb_gen_s;
  logic [1:0]  fb_attempt_s;

  logic        oob_reset_r;
  logic        link_up_r;
  logic        busy_r;
  logic        fail_r;
  logic        oob_reset_nxt_s;
  logic        link_up_nxt_s;
  logic        busy_nxt_s;
  logic        fail_nxt_s;

  // Fallback target: next retry at this gen, else one gen lower, else give up
  always_comb begin
    fb_state_s   = ST_RESET_OOB;
    fb_gen_s     = gen_r;
    fb_attempt_s = attempt_r;
    if (attempt_r < RETRY_LAST) begin
      fb_attempt_s = attempt_r + 2'd1;
    end else if (gen_r != 2'd0) begin
      fb_gen_s     = gen_r - 2'd1;
      fb_attempt_s = 2'd0;
    end else begin
      fb_state_s   = ST_FAILED;
    end
  end

  // Next-state logic: global overrides first, then per-state rules
  always_comb begin
    state_nxt_s   = state_r;
    gen_nxt_s     = gen_r;
    attempt_nxt_s = attempt_r;
    if (!nif.enable) begin
      state_nxt_s   = ST_IDLE;
      gen_nxt_s     = GEN_TOP;
      attempt_nxt_s = 2'd0;
    end else if (!nif.phy_ready && (state_r != ST_IDLE)) begin
      state_nxt_s   = ST_IDLE;
      gen_nxt_s     = GEN_TOP;
      attempt_nxt_s = 2'd0;
    end else if (nif.retrain && ((state_r == ST_WAIT_LINK) || (state_r == ST_CHECK_STABLE) ||
                                 (state_r == ST_LINKED) || (state_r == ST_FAILED))) begin
      state_nxt_s   = ST_RESET_OOB;
      gen_nxt_s     = GEN_TOP;
      attempt_nxt_s = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (nif.phy_ready) begin
            state_nxt_s   = ST_RESET_OOB;
            gen_nxt_s     = GEN_TOP;
            attempt_nxt_s = 2'd0;
          end else begin
            state_nxt_s   = ST_IDLE;
          end
        end
        ST_RESET_OOB: begin
          if (timer_r == HOLD_LAST) begin
            state_nxt_s = ST_WAIT_LINK;
          end else begin
            state_nxt_s = ST_RESET_OOB;
          end
        end
        ST_WAIT_LINK: begin
          // linkup takes precedence over a coincident timeout
          if (nif.oob_linkup) begin
            state_nxt_s   = ST_CHECK_STABLE;
          end else if (timer_r == TIMEOUT_LAST) begin
            state_nxt_s   = fb_state_s;
            gen_nxt_s     = fb_gen_s;
            attempt_nxt_s = fb_attempt_s;
          end else begin
            state_nxt_s   = ST_WAIT_LINK;
          end
        end
        ST_CHECK_STABLE: begin
          if (!nif.oob_linkup) begin
            state_nxt_s   = fb_state_s;
            gen_nxt_s     = fb_gen_s;
            attempt_nxt_s = fb_attempt_s;
          end else if (timer_r == STABLE_LAST) begin
            state_nxt_s   = ST_LINKED;
          end else begin
            state_nxt_s   = ST_CHECK_STABLE;
          end
        end
        ST_LINKED: begin
          if (!nif.oob_linkup) begin
            state_nxt_s   = ST_RESET_OOB;
            gen_nxt_s     = GEN_TOP;
            attempt_nxt_s = 2'd0;
          end else begin
            state_nxt_s   = ST_LINKED;
          end
        end
        ST_FAILED: begin
          state_nxt_s = ST_FAILED;
        end
        default: begin
          state_nxt_s   = ST_IDLE;
          gen_nxt_s     = GEN_TOP;
          attempt_nxt_s = 2'd0;
        end
      endcase
    end
  end

  // Shared timer: cleared on any state change, counts only in timed states
  always_comb begin
    timer_nxt_s = timer_r;
    if (state_nxt_s != state_r) begin
      timer_nxt_s = 24'd0;
    end else if ((state_r == ST_RESET_OOB) || (state_r == ST_WAIT_LINK) ||
                 (state_r == ST_CHECK_STABLE)) begin
      timer_nxt_s = timer_r + 24'd1;
    end else begin
      timer_nxt_s = 24'd0;
    end
  end

  // Output decode from the upcoming state so outputs register alongside it
  always_comb begin
    oob_reset_nxt_s = 1'b1;
    link_up_nxt_s   = 1'b0;
    busy_nxt_s      = 1'b0;
    fail_nxt_s      = 1'b0;
    case (state_nxt_s)
      ST_IDLE:         oob_reset_nxt_s = 1'b1;
      ST_RESET_OOB:    busy_nxt_s      = 1'b1;
      ST_WAIT_LINK: begin
        oob_reset_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
      end
      ST_CHECK_STABLE: begin
        oob_reset_nxt_s = 1'b0;
        busy_nxt_s      = 1'b1;
      end
      ST_LINKED: begin
        oob_reset_nxt_s = 1'b0;
        link_up_nxt_s   = 1'b1;
      end
      ST_FAILED:       fail_nxt_s      = 1'b1;
      default:         oob_reset_nxt_s = 1'b1;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      timer_r     <= 24'd0;
      gen_r       <= GEN_TOP;
      attempt_r   <= 2'd0;
      oob_reset_r <= 1'b1;
      link_up_r   <= 1'b0;
      busy_r      <= 1'b0;
      fail_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      gen_r       <= gen_nxt_s;
      attempt_r   <= attempt_nxt_s;
      oob_reset_r <= oob_reset_nxt_s;
      link_up_r   <= link_up_nxt_s;
      busy_r      <= busy_nxt_s;
      fail_r      <= fail_nxt_s;
    end
  end

  assign nif.gen       = gen_r;
  assign nif.attempt   = attempt_r;
  assign nif.oob_reset = oob_reset_r;
  assign nif.link_up   = link_up_r;
  assign nif.busy      = busy_r;
  assign nif.fail      = fail_r;
  assign nif.state_dbg = state_r;

endmodule

// File: tb/tb_sata_speed_negotiator.sv
// Bench for sata_speed_negotiator: directed scenarios followed by random
// traffic, every cycle compared against an attempt-index reference model.
module tb_sata_speed_negotiator;

  localparam int MAXG = 2;
  localparam int TO   = 100;
  localparam int RPG  = 2;
  localparam int RH   = 4;
  localparam int SC   = 8;
  localparam int NATT = RPG * (MAXG + 1);

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;

  sata_speed_negotiator_if nif ();

  sata_speed_negotiator #(
    .MAX_GEN(MAXG), .TIMEOUT_CYCLES(24'd100), .RETRIES_PER_GEN(RPG),
    .RESET_HOLD(RH), .STABLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .nif(nif)
  );

  always #5 clk = ~clk;

  // Reference model: link mode flags plus a global attempt index k
  // (gen = MAXG - k/RPG, attempt = k%RPG), t = cycles since attempt start,
  // h = consecutive linkup cycles seen so far in this attempt.
  bit m_idle, m_linked, m_failed;
  int m_k, m_t, m_h;

  task automatic m_go_idle();
    m_idle = 1'b1; m_linked = 1'b0; m_failed = 1'b0;
    m_k = 0; m_t = 0; m_h = 0;
  endtask

  task automatic m_restart();
    m_idle = 1'b0; m_linked = 1'b0; m_failed = 1'b0;
    m_k = 0; m_t = 0; m_h = 0;
  endtask

  task automatic m_fallback();
    m_t = 0; m_h = 0;
    if (m_k + 1 >= NATT) m_failed = 1'b1;
    else m_k = m_k + 1;
  endtask

  task automatic m_step();
    bit neg, in_hold;
    neg     = !m_idle && !m_linked && !m_failed;
    in_hold = neg && (m_t < RH);
    if (!nif.enable) m_go_idle();
    else if (!nif.phy_ready && !m_idle) m_go_idle();
    else if (nif.retrain && !m_idle && !in_hold) m_restart();
    else if (m_idle) begin
      if (nif.phy_ready) m_restart();
    end else if (m_failed) begin
      m_failed = 1'b1;
    end else if (m_linked) begin
      if (!nif.oob_linkup) m_restart();
    end else if (in_hold) begin
      m_t++;
    end else if (m_h == 0) begin
      if (nif.oob_linkup) m_h = 1;
      else if (m_t - RH == TO - 1) m_fallback();
      else m_t++;
    end else begin
      if (!nif.oob_linkup) m_fallback();
      else if (m_h == SC) m_linked = 1'b1;
      else m_h++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic check_all();
    int e_state;
    e_state = m_idle ? 0 : m_failed ? 5 : m_linked ? 4 : (m_t < RH) ? 1 : (m_h == 0) ? 2 : 3;
    chk("state_dbg", 8'(nif.state_dbg), 8'(e_state));
    chk("gen",       8'(nif.gen),       8'(MAXG - m_k / RPG));
    chk("attempt",   8'(nif.attempt),   8'(m_k % RPG));
    chk("oob_reset", 8'(nif.oob_reset), 8'(e_state == 0 || e_state == 1 || e_state == 5));
    chk("link_up",   8'(nif.link_up),   8'(e_state == 4));
    chk("busy",      8'(nif.busy),      8'(e_state >= 1 && e_state <= 3));
    chk("fail",      8'(nif.fail),      8'(e_state == 5));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) m_go_idle();
    else m_step();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    nif.enable = 1'b0; nif.phy_ready = 1'b0; nif.oob_linkup = 1'b0; nif.retrain = 1'b0;
    m_go_idle();
    ticks(2);
    reset = 1'b0;

    // 1: clean link at gen 2, linkup 20 cycles into WAIT_LINK
    nif.enable = 1'b1; nif.phy_ready = 1'b1;
    ticks(RH + 20);
    nif.oob_linkup = 1'b1;
    ticks(SC + 3);
    chk("s1_link_up", 8'(nif.link_up), 8'd1);
    chk("s1_gen", 8'(nif.gen), 8'd2);

    // 5a: link loss in LINKED
    nif.oob_linkup = 1'b0;
    tick();
    chk("s5a_link_up", 8'(nif.link_up), 8'd0);
    chk("s5a_state", 8'(nif.state_dbg), 8'd1);

    // 2: no linkup at all -> six attempts then FAILED
    ticks(NATT * (RH + TO) + 5);
    chk("s2_fail", 8'(nif.fail), 8'd1);
    chk("s2_state", 8'(nif.state_dbg), 8'd5);

    // 3: retrain from FAILED, gen 2 times out twice, link at gen 1
    nif.retrain = 1'b1; tick(); nif.retrain = 1'b0;
    ticks(RPG * (RH + TO) - 1 + RH + 10);
    nif.oob_linkup = 1'b1;
    ticks(SC + 3);
    chk("s3_gen", 8'(nif.gen), 8'd1);
    chk("s3_attempt", 8'(nif.attempt), 8'd0);
    chk("s3_link_up", 8'(nif.link_up), 8'd1);

    // 5b: retrain pulse in LINKED
    nif.retrain = 1'b1; tick(); nif.retrain = 1'b0;
    chk("s5b_gen", 8'(nif.gen), 8'd2);
    chk("s5b_state", 8'(nif.state_dbg), 8'd1);

    // 4: short linkup burst in CHECK_STABLE -> retry at same gen
    nif.oob_linkup = 1'b0;
    ticks(RH + 5);
    nif.oob_linkup = 1'b1;
    ticks(5);
    nif.oob_linkup = 1'b0;
    tick();
    chk("s4_attempt", 8'(nif.attempt), 8'd1);
    chk("s4_gen", 8'(nif.gen), 8'd2);

    // 6a: phy_ready drop mid-WAIT_LINK
    ticks(RH + 3);
    nif.phy_ready = 1'b0; tick();
    chk("s6a_state", 8'(nif.state_dbg), 8'd0);
    chk("s6a_oob_reset", 8'(nif.oob_reset), 8'd1);
    nif.phy_ready = 1'b1;

    // 6b: async reset while in CHECK_STABLE
    ticks(RH + 1);
    nif.oob_linkup = 1'b1;
    ticks(4);
    #2 reset = 1'b1;
    #1 m_go_idle();
    check_all();
    tick();
    #2 reset = 1'b0;

    // 6c: enable low while FAILED
    nif.oob_linkup = 1'b0;
    ticks(NATT * (RH + TO) + 5);
    nif.enable = 1'b0; tick();
    chk("s6c_fail", 8'(nif.fail), 8'd0);
    chk("s6c_state", 8'(nif.state_dbg), 8'd0);

    // Random traffic against the model
    nif.enable = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) nif.enable = ~nif.enable;
      nif.phy_ready = ($urandom_range(0, 149) != 0);
      nif.retrain   = ($urandom_range(0, 119) == 0);
      if ($urandom_range(0, 15) == 0) nif.oob_linkup = ~nif.oob_linkup;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
